yubex_edge_rate_meter: RTL and testbench

YUBEX_EDGE_RATE_METER -- requirements
Module: yubex_edge_rate_meter

---
 rtl/yubex_la_pkg.sv | 23 ++
 rtl/yubex_hex7seg.sv | 12 +
 rtl/yubex_edge_rate_meter.sv | 96 +++++++++
 tb/tb_yubex_edge_rate_meter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/yubex_la_pkg.sv
// Shared definitions for the logic-analyzer probe blocks.
// Edge-select encodings and the 7-segment glyph table.
package yubex_la_pkg;

    typedef enum logic [1:0] {
        SEL_RISE   = 2'b00,
        SEL_FALL   = 2'b01,
        SEL_BOTH   = 2'b10,
        SEL_FREEZE = 2'b11
    } edge_sel_e;

    // Saturation value of the event counter: "more than 15".
    localparam logic [4:0] EVT_SAT = 5'd16;

    // Active-high a..g patterns, listed from digit F down to digit 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/yubex_hex7seg.sv
// Hex digit to 7-segment decoder, purely combinational.
// Segment bit0 is a, bit6 is g, active-high.
module yubex_hex7seg
    import yubex_la_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/yubex_edge_rate_meter.sv
// Counts edges of an asynchronous probe over a fixed clock window
// and shows the last window's count on a 7-segment digit.
module yubex_edge_rate_meter
    import yubex_la_pkg::*;
#(
    parameter int GATE_CYCLES = 12500,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    input  logic [1:0] edge_sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic       gate
);

    localparam int CW = $clog2(GATE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(GATE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [CW-1:0]          win_q, win_d;
    logic [4:0]             evt_q, evt_d;
    logic [3:0]             res_q, res_d;
    logic                   ovf_q, ovf_d;
    logic                   gate_q;

    edge_sel_e sel;
    logic      sync_last;
    logic      rise, fall, strobe, term;

    assign sel       = edge_sel_e'(edge_sel);
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign rise      = sync_last & ~dly_q;
    assign fall      = ~sync_last & dly_q;
    assign term      = (win_q == TERM);

    // Freeze only holds the display; events keep counting as rising.
    always_comb begin
        strobe = 1'b0;
        unique case (sel)
            SEL_RISE:   strobe = rise;
            SEL_FALL:   strobe = fall;
            SEL_BOTH:   strobe = rise | fall;
            SEL_FREEZE: strobe = rise;
            default:    strobe = rise;
        endcase
    end

    always_comb begin
        win_d = term ? '0 : win_q + 1'b1;
        evt_d = evt_q;
        res_d = res_q;
        ovf_d = ovf_q;
        if (term) begin
            // A strobe in the terminal cycle opens the next window.
            evt_d = {4'b0, strobe};
            if (sel != SEL_FREEZE) begin
                res_d = evt_q[4] ? 4'hF : evt_q[3:0];
                ovf_d = evt_q[4];
            end
        end else if (strobe && evt_q != EVT_SAT) begin
            evt_d = evt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            win_q  <= '0;
            evt_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            gate_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            dly_q  <= sync_last;
            win_q  <= win_d;
            evt_q  <= evt_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            gate_q <= term;
        end
    end

    yubex_hex7seg u_hex7seg (
        .hex_i (res_q),
        .seg_o (seg)
    );

    assign dp   = ovf_q;
    assign gate = gate_q;

endmodule

// File: tb/tb_yubex_edge_rate_meter.sv
// Directed bench for yubex_edge_rate_meter, 16-cycle windows.
// Each vector drives one whole window of sig and checks the display.
module tb_yubex_edge_rate_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig;
    logic [1:0] edge_sel;
    logic [6:0] seg;
    logic       dp;
    logic       gate;

    int passed = 0;
    int total  = 0;

    yubex_edge_rate_meter #(
        .GATE_CYCLES (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .edge_sel (edge_sel),
        .seg      (seg),
        .dp       (dp),
        .gate     (gate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [15:0] pat;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives sig bit k just after window edge k; sel_b takes over at k=8.
    task automatic run_window(input string nm, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [15:0] pat,
                              input logic [6:0] eseg, input logic edp);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 16; k++) begin
            edge_sel = (k < 8) ? sa : sb;
            sig      = pat[k];
            step();
            if (k < 15 && gate !== 1'b0) bad = 1'b1;
        end
        chk({nm, "_gate_low"}, {7'b0, bad}, 8'd0);
        chk({nm, "_gate"}, {7'b0, gate}, 8'd1);
        chk({nm, "_seg"}, {1'b0, seg}, {1'b0, eseg});
        chk({nm, "_dp"}, {7'b0, dp}, {7'b0, edp});
    endtask

    task automatic do_reset(input logic s);
        rst = 1'b1;
        sig = s;
        #3;
        chk("rst_seg", {1'b0, seg}, 8'h3F);
        chk("rst_dp", {7'b0, dp}, 8'd0);
        chk("rst_gate", {7'b0, gate}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 2'b00, 16'h0155, 7'h6D, 1'b0};
        vecs[1]  = '{2'b01, 2'b01, 16'h0055, 7'h66, 1'b0};
        vecs[2]  = '{2'b10, 2'b10, 16'h0055, 7'h7F, 1'b0};
        vecs[3]  = '{2'b00, 2'b00, 16'h0000, 7'h3F, 1'b0};
        vecs[4]  = '{2'b10, 2'b10, 16'h5555, 7'h5E, 1'b0};
        vecs[5]  = '{2'b10, 2'b10, 16'h5555, 7'h71, 1'b1};
        vecs[6]  = '{2'b10, 2'b10, 16'h0000, 7'h4F, 1'b0};
        vecs[7]  = '{2'b00, 2'b00, 16'hE005, 7'h5B, 1'b0};
        vecs[8]  = '{2'b00, 2'b00, 16'h0000, 7'h06, 1'b0};
        vecs[9]  = '{2'b00, 2'b00, 16'hF555, 7'h07, 1'b0};
        vecs[10] = '{2'b11, 2'b11, 16'h0AAA, 7'h07, 1'b0};
        vecs[11] = '{2'b11, 2'b11, 16'h0AAA, 7'h07, 1'b0};
        vecs[12] = '{2'b11, 2'b11, 16'hEAAA, 7'h07, 1'b0};
        vecs[13] = '{2'b00, 2'b00, 16'h02AA, 7'h7D, 1'b0};
        vecs[14] = '{2'b00, 2'b01, 16'h0155, 7'h6D, 1'b0};

        edge_sel = 2'b00;
        do_reset(1'b0);

        for (int i = 0; i < 15; i++) begin
            run_window($sformatf("vec%0d", i), vecs[i].sel_a,
                       vecs[i].sel_b, vecs[i].pat, vecs[i].seg,
                       vecs[i].dp);
        end

        // Reset in the middle of a counting window.
        edge_sel = 2'b00;
        for (int k = 0; k < 10; k++) begin
            sig = (k % 2 == 0);
            step();
        end
        #2;
        do_reset(1'b0);
        run_window("post_rst", 2'b00, 2'b00, 16'h0000, 7'h3F, 1'b0);

        // sig high out of reset counts as one rising edge.
        do_reset(1'b1);
        run_window("hi_rst", 2'b00, 2'b00, 16'hFFFF, 7'h06, 1'b0);
        run_window("hi_hold", 2'b00, 2'b00, 16'hFFFF, 7'h3F, 1'b0);

        // Last rise that still lands inside the window.
        do_reset(1'b0);
        run_window("lat_in", 2'b00, 2'b00, 16'hF000, 7'h06, 1'b0);
        run_window("lat_in2", 2'b00, 2'b00, 16'hFFFF, 7'h3F, 1'b0);

        // One cycle later the strobe hits the terminal cycle.
        do_reset(1'b0);
        run_window("lat_term", 2'b00, 2'b00, 16'hE000, 7'h3F, 1'b0);
        run_window("lat_next", 2'b00, 2'b00, 16'hFFFF, 7'h06, 1'b0);
        run_window("fall_only", 2'b00, 2'b00, 16'h0000, 7'h3F, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
